// File: rtl/swan_pkg.sv
// Shared widths, word counts and controller states for the SWAN-128/256 word front end.
package swan_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int BLOCK_SIZE      = 128;
  localparam int KEY_SIZE        = 256;
  localparam int WORDS_PER_BLOCK = BLOCK_SIZE / WORD_SIZE;
  localparam int WORDS_PER_KEY   = KEY_SIZE / WORD_SIZE;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/swan_word_pack.sv
// Word-indexed big-endian load register: each write lands at the current word slot,
// the slot counter wraps after the last word, full flag tracks a complete fill.
module swan_word_pack
  import swan_pkg::*;
#(
  parameter  int WORDS  = WORDS_PER_BLOCK,
  parameter  int WORD_W = WORD_SIZE,
  localparam int CW     = $clog2(WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_i,
  input  logic [0:WORD_W-1]       data_i,
  output logic [0:WORDS*WORD_W-1] reg_o,
  output logic [CW-1:0]           cnt_o,
  output logic                    last_o,
  output logic                    full_o
);

  logic [0:WORDS*WORD_W-1] reg_q, reg_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    full_q, full_d;
  logic                    last;

  assign last = (cnt_q == CW'(WORDS - 1));

  always_comb begin
    reg_d  = reg_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (wr_i) begin
      reg_d[int'(cnt_q) * WORD_W +: WORD_W] = data_i;
      // Starting a new fill invalidates the previous one until it completes again.
      if (cnt_q == '0) full_d = 1'b0;
      if (last) begin
        full_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign reg_o  = reg_q;
  assign cnt_o  = cnt_q;
  assign last_o = last;
  assign full_o = full_q;

endmodule

// File: rtl/swan128k256_word_io.sv
// 32-bit word-stream wrapper around a serial SWAN-128/256 core: packs key and block,
// kicks the core, and streams the 128-bit result back out as four words.
//
// state | meaning
// LOAD  | accept key words (no partial block) and data words (key loaded)
// START | one-cycle core_start pulse, core_ready ignored
// BUSY  | wait for core_ready, then capture core_out
// DRAIN | emit four result words on m_* stream
module swan128k256_word_io
  import swan_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [0:WORD_SIZE-1]  s_data,
  input  logic                  s_is_key,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [0:WORD_SIZE-1]  m_data,
  output logic                  m_last,
  output logic                  core_start,
  output logic [0:KEY_SIZE-1]   core_key,
  output logic [0:BLOCK_SIZE-1] core_inp,
  input  logic                  core_ready,
  input  logic [0:BLOCK_SIZE-1] core_out
);

  state_e                 state_q, state_d;
  logic [0:BLOCK_SIZE-1]  out_q, out_d;
  logic [1:0]             ocnt_q, ocnt_d;

  logic                   key_wr, data_wr;
  logic                   key_loaded;
  logic [1:0]             dcnt;
  logic                   blk_last;
  logic [2:0]             key_cnt_unused;
  logic                   key_last_unused;
  logic                   blk_full_unused;

  assign key_wr  = s_valid & s_ready & s_is_key;
  assign data_wr = s_valid & s_ready & ~s_is_key;

  swan_word_pack #(.WORDS(WORDS_PER_KEY), .WORD_W(WORD_SIZE)) u_key_pack (
    .clk_i  (clk),
    .rst_ni (rst),
    .wr_i   (key_wr),
    .data_i (s_data),
    .reg_o  (core_key),
    .cnt_o  (key_cnt_unused),
    .last_o (key_last_unused),
    .full_o (key_loaded)
  );

  swan_word_pack #(.WORDS(WORDS_PER_BLOCK), .WORD_W(WORD_SIZE)) u_blk_pack (
    .clk_i  (clk),
    .rst_ni (rst),
    .wr_i   (data_wr),
    .data_i (s_data),
    .reg_o  (core_inp),
    .cnt_o  (dcnt),
    .last_o (blk_last),
    .full_o (blk_full_unused)
  );

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    ocnt_d     = ocnt_q;
    s_ready    = 1'b0;
    core_start = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_last     = 1'b0;
    case (state_q)
      LOAD: begin
        // A key reload mid-block would change the key under a half-built block.
        s_ready = s_is_key ? (dcnt == 2'd0) : key_loaded;
        if (s_valid && s_ready && !s_is_key && blk_last) state_d = START;
      end
      START: begin
        core_start = 1'b1;
        state_d    = BUSY;
      end
      BUSY: begin
        if (core_ready) begin
          out_d   = core_out;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_data  = out_q[int'(ocnt_q) * WORD_SIZE +: WORD_SIZE];
        m_last  = (ocnt_q == 2'(WORDS_PER_BLOCK - 1));
        if (m_ready) begin
          if (m_last) begin
            ocnt_d  = 2'd0;
            state_d = LOAD;
          end else begin
            ocnt_d = ocnt_q + 2'd1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      out_q   <= '0;
      ocnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ocnt_q  <= ocnt_d;
    end
  end

endmodule

// File: tb/tb_swan128k256_word_io.sv
// Bench for swan128k256_word_io: stand-in cipher core with random latency, a word-level
// reference model checked every cycle, directed corner cases, then random traffic.
module tb_swan128k256_word_io;

  logic         clk = 1'b0;
  logic         rst, s_valid, s_ready, s_is_key, m_valid, m_ready, m_last;
  logic         core_start, core_ready;
  logic [0:31]  s_data, m_data;
  logic [0:255] core_key;
  logic [0:127] core_inp, core_out;

  always #5 clk = ~clk;

  swan128k256_word_io dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_is_key   (s_is_key),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .core_start (core_start),
    .core_key   (core_key),
    .core_inp   (core_inp),
    .core_ready (core_ready),
    .core_out   (core_out)
  );

  localparam int P_FILL = 0, P_KICK = 1, P_WAIT = 2, P_EMIT = 3;

  // reference model
  int          ph, kfill, dfill, ocnt;
  bit          key_ok;
  logic [31:0] mk [8];
  logic [31:0] mb [4];
  logic [31:0] mr [4];

  // core stand-in
  bit           stub_busy;
  int           stub_cnt;
  logic [0:127] stub_res;

  // stimulus requests and observations
  logic        st_rst_n, st_valid, st_key, st_mready;
  logic [31:0] st_data;
  bit          last_accept;
  int          tests, fails, hs_count, starts_seen;
  logic [31:0] got_q [$];

  function automatic logic [0:127] mix(input logic [31:0] k [8], input logic [31:0] b [4]);
    logic [0:127] r;
    for (int i = 0; i < 4; i++)
      r[i*32 +: 32] = (b[i] ^ k[i] ^ {k[i+4][24:0], k[i+4][31:25]}) + 32'h9e3779b9 * i;
    return r;
  endfunction

  function automatic logic [0:255] pack8(input logic [31:0] w [8]);
    logic [0:255] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = w[i];
    return r;
  endfunction

  function automatic logic [0:127] pack4(input logic [31:0] w [4]);
    logic [0:127] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = w[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: bound expired, got no event expected event (t=%0t)", nm, $time);
  endtask

  task automatic model_reset();
    ph = P_FILL; kfill = 0; dfill = 0; ocnt = 0; key_ok = 0;
    for (int i = 0; i < 8; i++) mk[i] = '0;
    for (int i = 0; i < 4; i++) begin mb[i] = '0; mr[i] = '0; end
  endtask

  task automatic step();
    bit           exp_sready;
    logic [31:0]  exp_mdata;
    logic [31:0]  kw [8];
    logic [31:0]  bw [4];
    logic [0:127] res;
    @(negedge clk);
    rst = st_rst_n; s_valid = st_valid; s_is_key = st_key; s_data = st_data; m_ready = st_mready;
    if (!st_rst_n) model_reset();
    if (stub_busy) begin
      if (stub_cnt == 0) begin
        core_ready = 1'b1; core_out = stub_res; stub_busy = 0;
      end else begin
        core_ready = 1'b0; stub_cnt--;
      end
    end else if (ph != P_WAIT && $urandom_range(0, 5) == 0) begin
      core_ready = 1'b1;
      core_out = {$urandom(), $urandom(), $urandom(), $urandom()};
    end else begin
      core_ready = 1'b0;
    end
    #1;
    exp_sready = (ph == P_FILL) && (st_key ? (dfill == 0) : key_ok);
    exp_mdata  = (ph == P_EMIT) ? mr[ocnt] : 32'h0;
    chk("s_ready", s_ready, exp_sready);
    chk("core_start", core_start, ph == P_KICK);
    chk("m_valid", m_valid, ph == P_EMIT);
    chk("m_last", m_last, (ph == P_EMIT) && (ocnt == 3));
    chk("m_data", m_data, exp_mdata);
    chk("core_key", core_key, pack8(mk));
    chk("core_inp", core_inp, pack4(mb));
    last_accept = s_valid && s_ready;
    if (m_valid && m_ready) begin got_q.push_back(m_data); hs_count++; end
    if (core_start) starts_seen++;
    if (st_rst_n) begin
      case (ph)
        P_FILL: if (st_valid && exp_sready) begin
          if (st_key) begin
            mk[kfill] = st_data;
            if (kfill == 0) key_ok = 0;
            if (kfill == 7) key_ok = 1;
            kfill = (kfill + 1) % 8;
          end else begin
            mb[dfill] = st_data;
            if (dfill == 3) begin dfill = 0; ph = P_KICK; end
            else dfill++;
          end
        end
        P_KICK: ph = P_WAIT;
        P_WAIT: if (core_ready) begin
          res = mix(mk, mb);
          for (int i = 0; i < 4; i++) mr[i] = res[i*32 +: 32];
          ph = P_EMIT;
        end
        default: if (st_mready) begin
          if (ocnt == 3) begin ocnt = 0; ph = P_FILL; end
          else ocnt++;
        end
      endcase
      if (core_start) begin
        for (int i = 0; i < 8; i++) kw[i] = core_key[i*32 +: 32];
        for (int i = 0; i < 4; i++) bw[i] = core_inp[i*32 +: 32];
        stub_res  = mix(kw, bw);
        stub_busy = 1;
        stub_cnt  = $urandom_range(0, 4);
      end
    end
  endtask

  task automatic send(input bit key, input logic [31:0] d);
    bit done = 0;
    st_valid = 1; st_key = key; st_data = d;
    for (int n = 0; n < 40 && !done; n++) begin
      step();
      done = last_accept;
    end
    st_valid = 0;
    if (!done) timeout("send_word");
  endtask

  task automatic wait_words(input int n);
    for (int c = 0; c < 60 && got_q.size() < n; c++) step();
    if (got_q.size() < n) timeout("drain_words");
  endtask

  task automatic wait_phase(input int p);
    for (int c = 0; c < 40 && ph != p; c++) step();
    if (ph != p) timeout("reach_phase");
  endtask

  initial begin
    logic [31:0] exp1 [4];
    logic [31:0] exp2 [4];
    logic [31:0] pat  [4];
    exp1 = '{32'h00000001, 32'h9e3779bb, 32'h3c6ef375, 32'hdaa66d2f};
    exp2 = '{32'h00000010, 32'h9e3779d9, 32'h3c6ef3a2, 32'hdaa66d6b};
    pat  = '{32'h1, 32'h0, 32'h0, 32'h1};
    tests = 0; fails = 0; hs_count = 0; starts_seen = 0; stub_busy = 0; stub_cnt = 0;
    rst = 1'b0; s_valid = 0; s_is_key = 0; s_data = '0; m_ready = 0;
    core_ready = 0; core_out = '0;
    model_reset();
    st_rst_n = 0; st_valid = 0; st_key = 0; st_data = '0; st_mready = 1;
    step(); step();
    chk("reset_m_valid", m_valid, 1'b0);
    chk("reset_core_key", core_key, 256'h0);
    st_rst_n = 1;

    // data before any key is refused
    st_valid = 1; st_key = 0; st_data = 32'hdeadbeef;
    step();
    chk("early_data_rejected", s_ready, 1'b0);
    step();
    st_valid = 0;

    for (int i = 0; i < 8; i++) send(1, 32'h0);
    send(0, 32'h1); send(0, 32'h2);
    st_valid = 1; st_key = 1; st_data = 32'hffffffff;
    step();
    chk("key_mid_block_rejected", s_ready, 1'b0);
    st_valid = 0;
    send(0, 32'h3); send(0, 32'h4);
    got_q.delete(); hs_count = 0;
    st_mready = 1;
    wait_words(4);
    for (int i = 0; i < 4; i++) begin
      chk("blk1_word", got_q[i], exp1[i]);
      chk("model_blk1_word", mr[i], exp1[i]);
    end
    chk("blk1_starts", starts_seen, 1);

    // key persists; stalled drain with m_ready 1,0,0,1
    got_q.delete(); hs_count = 0;
    st_mready = 0;
    send(0, 32'h10); send(0, 32'h20); send(0, 32'h30); send(0, 32'h40);
    wait_phase(P_EMIT);
    for (int i = 0; i < 4; i++) begin st_mready = pat[i][0]; step(); end
    st_mready = 1;
    wait_words(4);
    for (int i = 0; i < 3; i++) step();
    chk("stall_handshakes", hs_count, 4);
    for (int i = 0; i < 4; i++) chk("blk2_word", got_q[i], exp2[i]);
    chk("blk2_starts", starts_seen, 2);

    // reset while the core is busy
    got_q.delete(); hs_count = 0;
    send(0, 32'h50); send(0, 32'h60); send(0, 32'h70); send(0, 32'h80);
    wait_phase(P_WAIT);
    st_rst_n = 0;
    step();
    chk("busy_rst_m_valid", m_valid, 1'b0);
    chk("busy_rst_core_start", core_start, 1'b0);
    chk("busy_rst_core_inp", core_inp, 128'h0);
    st_rst_n = 1;
    st_valid = 1; st_key = 0; st_data = 32'h12345678;
    for (int i = 0; i < 8; i++) step();
    chk("post_rst_data_rejected", s_ready, 1'b0);
    chk("post_rst_no_output", hs_count, 0);
    st_valid = 0;

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      st_rst_n  = ($urandom_range(0, 799) != 0);
      st_valid  = ($urandom_range(0, 3) != 0);
      st_key    = ($urandom_range(0, 9) < (key_ok ? 2 : 7));
      st_data   = $urandom();
      st_mready = ($urandom_range(0, 2) != 0);
      step();
    end
    st_rst_n = 1; st_valid = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
